// File: rtl/curl_sponge_core.sv
// curl_sponge_core: Curl-P sponge engine absorbing 243-trit blocks and squeezing a 243-trit hash.
// Round count (27/81) is picked per message; ROUNDS_PER_CYCLE rounds are unrolled per clock.
module curl_sponge_core #(
   parameter int STATE_TRITS      = 729,
   parameter int RATE_TRITS       = 243,
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int TRIT_W           = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_rounds81,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [RATE_TRITS*TRIT_W-1:0] in_data,
   input  logic                         in_first,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [RATE_TRITS*TRIT_W-1:0] out_hash,
   output logic                         busy,
   output logic                         err_invalid_trit
);
   localparam int SW = STATE_TRITS * TRIT_W;
   localparam int RW = RATE_TRITS * TRIT_W;
   localparam int HALF = (STATE_TRITS - 1) / 2;
   localparam logic [6:0] C81 = 7'(81 / ROUNDS_PER_CYCLE - 1);
   localparam logic [6:0] C27 = 7'(27 / ROUNDS_PER_CYCLE - 1);
   localparam logic [8:0][1:0] TT = {2'b00, 2'b01, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b01};

   if (STATE_TRITS != 729 || TRIT_W != 2 || RATE_TRITS < 1 || RATE_TRITS > STATE_TRITS) begin : g_bad_geom
      $error("curl_sponge_core: unsupported state/rate/trit geometry");
   end
   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 3 && ROUNDS_PER_CYCLE != 9 && ROUNDS_PER_CYCLE != 27) begin : g_bad_rpc
      $error("curl_sponge_core: ROUNDS_PER_CYCLE must be 1, 3, 9 or 27");
   end

   typedef enum logic [1:0] {IDLE, ABSORB, XFORM, OUTPUT} fsm_t;

   fsm_t fsm, fsm_nx;
   logic started, r81, last_q, err_q, acc, xf_done;
   logic [6:0] cnt;
   logic [SW-1:0] s, rnd_out;
   logic [RW-1:0] blk;
   logic [RATE_TRITS-1:0] inv;

   // Trits are 2-bit two's complement, so a + 3b + 4 lands in 0..8 modulo 16.
   function automatic logic [1:0] tt(input logic [1:0] a, input logic [1:0] b);
      logic [3:0] idx;
      idx = {{2{a[1]}}, a} + 4'd3 * {{2{b[1]}}, b} + 4'd4;
      return TT[idx];
   endfunction

   for (genvar i = 0; i < RATE_TRITS; i++) begin : g_in
      assign inv[i] = in_data[TRIT_W*i +: TRIT_W] == 2'b10;
      assign blk[TRIT_W*i +: TRIT_W] = inv[i] ? 2'b00 : in_data[TRIT_W*i +: TRIT_W];
   end

   // p_k = 364*k mod 729 reproduces the +364/-365 walk as fixed wiring.
   for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_rnd
      logic [SW-1:0] src, nx;
      if (r == 0) begin : g_head
         assign src = s;
      end else begin : g_tail
         assign src = g_rnd[r-1].nx;
      end
      for (genvar i = 0; i < STATE_TRITS; i++) begin : g_trit
         localparam int PA = (HALF * i) % STATE_TRITS;
         localparam int PB = (HALF * (i + 1)) % STATE_TRITS;
         assign nx[TRIT_W*i +: TRIT_W] = tt(src[TRIT_W*PA +: TRIT_W], src[TRIT_W*PB +: TRIT_W]);
      end
   end
   assign rnd_out = g_rnd[ROUNDS_PER_CYCLE-1].nx;

   assign in_ready = started && (fsm == IDLE || fsm == ABSORB);
   assign acc = in_valid && in_ready;
   assign xf_done = fsm == XFORM && cnt == (r81 ? C81 : C27);
   assign out_valid = fsm == OUTPUT;
   assign out_hash = s[RW-1:0];
   assign busy = fsm != IDLE;
   assign err_invalid_trit = err_q;

   always_comb begin
      fsm_nx = fsm;
      fsm_nx = acc ? XFORM
             : xf_done ? (last_q ? OUTPUT : ABSORB)
             : (fsm == OUTPUT && out_ready) ? IDLE
             : fsm;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= IDLE;
      else fsm <= fsm_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s <= '0;
         started <= 1'b0;
         r81 <= 1'b0;
         last_q <= 1'b0;
         err_q <= 1'b0;
         cnt <= '0;
      end else begin
         started <= 1'b1;
         if (acc) begin
            s[RW-1:0] <= blk;
            if (in_first) s[SW-1:RW] <= '0;
            if (in_first) r81 <= cfg_rounds81;
            last_q <= in_last;
            err_q <= (err_q && !in_first) || |inv;
            cnt <= '0;
         end else if (fsm == XFORM) begin
            s <= rnd_out;
            cnt <= cnt + 7'd1;
         end
      end
   end
endmodule

// File: tb/tb_curl_sponge_core.sv
// tb_curl_sponge_core: randomized checks of curl_sponge_core against a trit-array Curl-P model.
module tb_curl_sponge_core;
   localparam int RPC = 3;
   localparam int RW = 486;

   logic clk = 1'b0, rst_n = 1'b0, cfg_rounds81 = 1'b0, in_valid = 1'b0;
   logic in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [RW-1:0] in_data = '0;
   logic in_ready, out_valid, busy, err_invalid_trit;
   logic [RW-1:0] out_hash;

   int cyc = 0, n_cmp = 0, n_err = 0;
   int ms[729];
   int pidx[730];
   int tt_m[9] = '{1, 0, -1, 1, -1, 0, -1, 1, 0};
   bit m_r81 = 1'b0;

   curl_sponge_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_rounds81(cfg_rounds81),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
      .busy(busy), .err_invalid_trit(err_invalid_trit)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int dec(input logic [1:0] t);
      return t == 2'b01 ? 1 : t == 2'b11 ? -1 : 0;
   endfunction

   function automatic logic [1:0] enc(input int v);
      return v == 1 ? 2'b01 : v == -1 ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [RW-1:0] m_hash();
      logic [RW-1:0] h;
      for (int i = 0; i < 243; i++) h[2*i +: 2] = enc(ms[i]);
      return h;
   endfunction

   function automatic logic [RW-1:0] rand_blk();
      logic [RW-1:0] b;
      for (int i = 0; i < 243; i++) begin
         int t;
         t = $urandom_range(0, 2);
         b[2*i +: 2] = t == 0 ? 2'b00 : t == 1 ? 2'b01 : 2'b11;
      end
      return b;
   endfunction

   task automatic m_xform(input int r);
      int tmp[729];
      repeat (r) begin
         tmp = ms;
         for (int i = 0; i < 729; i++) ms[i] = tt_m[tmp[pidx[i]] + 3 * tmp[pidx[i+1]] + 4];
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 729; i++) ms[i] = 0;
      m_r81 = 1'b0;
   endtask

   function automatic int exp_lat();
      return (m_r81 ? 81 : 27) / RPC + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit first, input bit last, input bit cfg, input logic [RW-1:0] d, output int hs);
      in_valid = 1'b1;
      in_first = first;
      in_last = last;
      cfg_rounds81 = cfg;
      in_data = d;
      hs = -1;
      for (int k = 0; k < 300 && hs < 0; k++) begin
         if (in_ready) hs = cyc;
         step();
      end
      in_valid = 1'b0;
      if (hs < 0) check("send_ready", RW'(in_ready), RW'(1));
      else begin
         if (first) begin
            for (int i = 0; i < 729; i++) ms[i] = 0;
            m_r81 = cfg;
         end
         for (int i = 0; i < 243; i++) ms[i] = dec(d[2*i +: 2]);
         m_xform(m_r81 ? 81 : 27);
      end
   endtask

   task automatic wait_out(input string tag, input int hs);
      int k;
      k = 0;
      while (!out_valid && k < 400) begin
         step();
         k++;
      end
      check({tag, "_valid"}, RW'(out_valid), RW'(1));
      check({tag, "_lat"}, RW'(cyc - hs), RW'(exp_lat()));
      check({tag, "_hash"}, out_hash, m_hash());
   endtask

   task automatic msg(input string tag, input int n, input bit cfg);
      int hs;
      for (int b = 0; b < n; b++) send(b == 0, b == n - 1, cfg, rand_blk(), hs);
      wait_out(tag, hs);
      step();
      check({tag, "_pulse"}, RW'(out_valid), RW'(0));
   endtask

   initial begin
      int hs, hs0, hs1, hs2;
      bit ok;
      logic [RW-1:0] d, h;
      pidx[0] = 0;
      for (int k = 0; k < 729; k++) pidx[k+1] = pidx[k] < 365 ? pidx[k] + 364 : pidx[k] - 365;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", RW'({in_ready, out_valid, busy, err_invalid_trit}), RW'(0));
      check("rst_hash", out_hash, '0);
      rst_n = 1'b1;
      #1;
      check("ready_pre", RW'(in_ready), RW'(0));
      step();
      check("ready_post", RW'(in_ready), RW'(1));

      // single zero block, Curl-P-81, out_ready high
      send(1'b1, 1'b1, 1'b1, '0, hs);
      wait_out("p81_zero", hs);
      step();
      check("p81_pulse", RW'(out_valid), RW'(0));
      check("p81_idle", RW'(busy), RW'(0));

      // three-block Curl-P-27 with cfg toggled mid-message (must be ignored)
      send(1'b1, 1'b0, 1'b0, rand_blk(), hs0);
      send(1'b0, 1'b0, 1'b1, rand_blk(), hs1);
      send(1'b0, 1'b1, 1'b1, rand_blk(), hs2);
      check("blk1_cyc", RW'(hs1 - hs0), RW'(27 / RPC + 1));
      check("blk2_cyc", RW'(hs2 - hs0), RW'(2 * (27 / RPC + 1)));
      wait_out("p27_3blk", hs2);
      step();

      // continuation from IDLE keeps state and latched round count
      send(1'b0, 1'b1, 1'b1, rand_blk(), hs);
      wait_out("cont", hs);
      step();

      // backpressure on the hash output
      out_ready = 1'b0;
      send(1'b1, 1'b1, 1'b1, rand_blk(), hs);
      wait_out("bp", hs);
      h = out_hash;
      ok = 1'b1;
      repeat (50) begin
         step();
         if (!out_valid || out_hash !== h || in_ready) ok = 1'b0;
      end
      check("bp_stable", RW'(ok), RW'(1));
      out_ready = 1'b1;
      step();
      check("bp_release", RW'({out_valid, busy, in_ready}), RW'(3'b001));

      // invalid trit 5 absorbed as zero, sticky until next first block
      d = rand_blk();
      d[11:10] = 2'b10;
      send(1'b1, 1'b1, 1'b0, d, hs);
      check("err_set", RW'(err_invalid_trit), RW'(1));
      wait_out("inv", hs);
      step();
      send(1'b0, 1'b1, 1'b0, rand_blk(), hs);
      check("err_sticky", RW'(err_invalid_trit), RW'(1));
      wait_out("inv_cont", hs);
      step();
      send(1'b1, 1'b1, 1'b0, rand_blk(), hs);
      check("err_clear", RW'(err_invalid_trit), RW'(0));
      wait_out("inv_clr", hs);
      step();

      // restart: a first block arriving in ABSORB discards the prior message
      send(1'b1, 1'b0, 1'b1, rand_blk(), hs);
      send(1'b1, 1'b1, 1'b0, rand_blk(), hs);
      wait_out("restart", hs);
      step();

      for (int m = 0; m < 6; m++) msg($sformatf("rnd%0d", m), $urandom_range(1, 3), 1'($urandom_range(0, 1)));

      // reset in the middle of a transform
      d = rand_blk();
      d[1:0] = 2'b10;
      send(1'b1, 1'b1, 1'b1, d, hs);
      repeat (13) step();
      rst_n = 1'b0;
      #1;
      check("midrst_ctl", RW'({in_ready, out_valid, busy, err_invalid_trit}), RW'(0));
      check("midrst_hash", out_hash, '0);
      m_reset();
      step();
      rst_n = 1'b1;
      step();
      check("midrst_ready", RW'(in_ready), RW'(1));
      ok = 1'b1;
      repeat (40) begin
         step();
         if (out_valid) ok = 1'b0;
      end
      check("midrst_nopulse", RW'(ok), RW'(1));
      msg("post_rst", 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/curl_sponge_core.md
Name: curl_sponge_core

Overview:
- Parametrised Curl-P sponge engine for IOTA hashing.
- Holds a 729-trit state. Absorbs 243-trit blocks over a valid/ready input stream and runs the Curl transform. After the last block of a message it emits the 243-trit hash over a valid/ready output stream.
- Generalises the single-transform Curl function in two ways: round count is selectable at run time (27 or 81), and the unroll factor is set at build time.
- Sits between the trinary input packer and the PoW/hash result logic. Uses trinary_pkg encoding and curl_const_pkg constants.

Parameters:
- STATE_TRITS, 729, sponge state length (fixed Curl value; checked by elaboration assertion).
- RATE_TRITS, 243, absorb/squeeze block length.
- ROUNDS_PER_CYCLE, 1, rounds computed per clock. Legal values: 1, 3, 9, 27. Any other value is an elaboration error.
- TRIT_W, 2, bits per trit. Encoding: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1, 2'b10 = invalid.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_rounds81  in  1  1 = Curl-P-81, 0 = Curl-P-27. Sampled on the first block of each message.
- in_valid  in  1  input block valid.
- in_ready  out  1  core can accept a block.
- in_data  in  RATE_TRITS*TRIT_W  243 trits; trit i occupies bits [2i+1:2i].
- in_first  in  1  block starts a new message; state is cleared before absorb.
- in_last  in  1  final block of the message.
- out_valid  out  1  hash valid.
- out_ready  in  1  downstream accepts hash.
- out_hash  out  RATE_TRITS*TRIT_W  state trits 0..242 after the final transform.
- busy  out  1  high in every state except IDLE.
- err_invalid_trit  out  1  sticky; set when an accepted block contains a 2'b10 trit. Cleared only by an accepted in_first block or by reset.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_hash=0, busy=0, err_invalid_trit=0, state=all zero, FSM=IDLE. in_ready rises one cycle after reset deassertion.
- FSM states: IDLE, ABSORB, XFORM, OUTPUT.
  - IDLE: in_ready=1. A transfer with in_first=1 clears the state, latches cfg_rounds81, writes state[0..242] <- in_data, and goes to XFORM.
  - IDLE, transfer with in_first=0: block is absorbed into the existing state (message continuation) and the FSM goes to XFORM.
  - ABSORB: entered after a non-last transform; in_ready=1. Absorb rule is the same as IDLE. in_first=1 here restarts the message and discards the prior state.
  - XFORM: in_ready=0. Runs R = 27 or 81 rounds at ROUNDS_PER_CYCLE rounds per clock, i.e. R/ROUNDS_PER_CYCLE cycles.
  - XFORM exit: if the latched last flag is set, go to OUTPUT; otherwise go to ABSORB.
  - OUTPUT: out_valid=1, out_hash holds state[0..242] stably. When out_valid && out_ready, go to IDLE on the next cycle. out_valid must not drop without a handshake.
- Round function: per round, new[i] = TT[s[p_i] + 3*s[p_{i+1}] + 4] for i = 0..728.
  - TT = {+1, 0, -1, +1, -1, 0, -1, +1, 0}.
  - Index sequence: p_0 = 0; p_{k+1} = p_k + 364 if p_k < 365, else p_k - 365.
  - The index sequence is a static wiring permutation; no run-time address arithmetic.
- Invalid trit (2'b10) on input: absorbed as 0 and err_invalid_trit is set.
- Latency: input handshake cycle to out_valid = R/ROUNDS_PER_CYCLE + 1 cycles for a single-block message. Examples: 82 cycles for R=81, RPC=1; 10 cycles for R=27, RPC=3.
- Throughput: the next block is accepted on the cycle after XFORM exits, with no bubble beyond that.
- cfg_rounds81 changes mid-message are ignored until the next in_first block.
- in_first and in_last both set: single-block message.
- in_valid while in_ready=0: held by the upstream; the core does not sample it.
- out_ready held high in OUTPUT: out_valid lasts exactly 1 cycle.
- Reset asserted mid-XFORM or in OUTPUT: immediate return to reset values; no partial hash is emitted.

Test Plan:
- Reset check: assert rst_n=0 mid-XFORM (cycle 40 of 81) -> all outputs 0 at once. After release, in_ready=1 within 1 cycle and out_valid never pulses.
- Single-block Curl-P-81: RPC=1, 243 zero trits, first=last=1 -> out_valid exactly 82 cycles after the handshake. out_hash matches the C reference model bit-exactly.
- Curl-P-27 with RPC=3: random 3-block message, out_ready=1 -> per-block XFORM lasts 9 cycles. Hash matches the model, and the blocks are accepted on cycles 0, 10 and 20.
- Backpressure: out_ready held 0 for 50 cycles -> out_valid and out_hash stable; in_ready=0 throughout. Releasing out_ready gives one transfer, then IDLE.
- Invalid trit: trit 5 = 2'b10 -> err_invalid_trit=1 and the hash equals the hash with trit 5 = 0. The next in_first block clears the flag.
- Restart: in_first=1 arriving in ABSORB mid-message -> prior state discarded; the hash equals the single-block hash of the new data.
